// File: rtl/hamming_pkg.sv
// Shared definitions for the serial extended-Hamming decoder: default code size,
// block geometry helpers and the control state encoding.
package hamming_pkg;

  localparam int R_DEFAULT = 4;

  function automatic int n_of(input int r);
    return 1 << r;
  endfunction

  function automatic int k_of(input int r);
    return (1 << r) - r - 1;
  endfunction

  // Positions 1, 2, 4, ... carry position parity; position 0 carries overall parity.
  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  typedef enum logic [1:0] {
    COLLECT,
    EVAL,
    EMIT
  } state_t;

endpackage

// File: rtl/hamming_stream_decoder_if.sv
// Signal bundle for the decoder's serial input, serial output and block status.
interface hamming_stream_decoder_if #(
  parameter int R = hamming_pkg::R_DEFAULT
);
  logic         in_bit;
  logic         in_valid;
  logic         in_ready;
  logic         out_bit;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [R-1:0] syndrome;
  logic         err_single;
  logic         err_double;
  logic         status_valid;

  modport master (
    output in_bit, in_valid, out_ready,
    input  in_ready, out_bit, out_valid, out_last,
    input  syndrome, err_single, err_double, status_valid
  );

  modport slave (
    input  in_bit, in_valid, out_ready,
    output in_ready, out_bit, out_valid, out_last,
    output syndrome, err_single, err_double, status_valid
  );
endinterface

// File: rtl/hamming_syndrome_acc.sv
// Running code-position counter with syndrome (XOR of indices of 1-bits) and
// overall parity accumulation for the block being collected.
module hamming_syndrome_acc
  import hamming_pkg::*;
#(
  parameter int R = R_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_accept,
  input  logic         i_bit,
  output logic [R-1:0] o_idx,
  output logic [R-1:0] o_syn,
  output logic         o_par
);

  logic [R-1:0] r_idx;
  logic [R-1:0] r_syn;
  logic         r_par;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_syn <= '0;
      r_par <= 1'b0;
    end else if (i_clear) begin
      r_idx <= '0;
      r_syn <= '0;
      r_par <= 1'b0;
    end else if (i_accept) begin
      r_idx <= r_idx + R'(1);
      if (i_bit) begin
        r_syn <= r_syn ^ r_idx;
        r_par <= ~r_par;
      end
    end
  end

  assign o_idx = r_idx;
  assign o_syn = r_syn;
  assign o_par = r_par;

endmodule

// File: rtl/hamming_stream_decoder.sv
// Serial extended-Hamming (SECDED) block decoder: collects N code bits, corrects
// a single error in one cycle, then streams the K data bits out in position order.
module hamming_stream_decoder
  import hamming_pkg::*;
#(
  parameter int R = R_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_bit,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [R-1:0] syndrome,
  output logic         err_single,
  output logic         err_double,
  output logic         status_valid
);

  localparam int N = n_of(R);
  localparam logic [R-1:0] FIRST_POS = R'(3);
  localparam logic [R-1:0] LAST_POS  = R'(N - 1);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_buf;
  logic [R-1:0] r_pos;
  logic [R-1:0] w_pos_inc;
  logic [R-1:0] w_pos_nxt;
  logic [R-1:0] w_idx;
  logic [R-1:0] w_syn;
  logic         w_par;
  logic         w_accept;
  logic         w_out_fire;
  logic         w_done;
  logic         w_correct;
  logic [R-1:0] r_syndrome;
  logic         r_err_single;
  logic         r_err_double;
  logic         r_status_valid;

  hamming_syndrome_acc #(.R(R)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_done),
    .i_accept (w_accept),
    .i_bit    (in_bit),
    .o_idx    (w_idx),
    .o_syn    (w_syn),
    .o_par    (w_par)
  );

  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_done     = w_out_fire && (r_pos == LAST_POS);
  assign w_correct  = w_par && (w_syn != '0);

  // Power-of-two positions are never adjacent past 3, so a skip of two suffices.
  assign w_pos_inc = r_pos + R'(1);
  assign w_pos_nxt = is_pow2(32'(w_pos_inc)) ? r_pos + R'(2) : w_pos_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COLLECT;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      COLLECT: begin
        in_ready = 1'b1;
        if (w_accept && (w_idx == LAST_POS)) w_state_nxt = EVAL;
      end
      EVAL:    w_state_nxt = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        if (w_done) w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= FIRST_POS;
    end else if (r_state == EVAL) begin
      r_pos <= FIRST_POS;
    end else if (w_out_fire) begin
      r_pos <= w_pos_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_syndrome     <= '0;
      r_err_single   <= 1'b0;
      r_err_double   <= 1'b0;
      r_status_valid <= 1'b0;
    end else begin
      r_status_valid <= (r_state == EVAL);
      if (r_state == EVAL) begin
        r_syndrome   <= w_syn;
        r_err_single <= w_par;
        r_err_double <= !w_par && (w_syn != '0);
      end
    end
  end

  // NOTE: the block buffer is plain storage with no reset; its contents are
  // meaningless until a full block has been collected, and out_bit is gated.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[w_idx] <= in_bit;
    end else if ((r_state == EVAL) && w_correct) begin
      r_buf[w_syn] <= ~r_buf[w_syn];
    end
  end

  assign out_bit      = out_valid && r_buf[r_pos];
  assign out_last     = out_valid && (r_pos == LAST_POS);
  assign syndrome     = r_syndrome;
  assign err_single   = r_err_single;
  assign err_double   = r_err_double;
  assign status_valid = r_status_valid;

endmodule
